vram_arb: RTL and testbench

VRAM_ARB -- requirements
Module: vram_arb

---
 rtl/vram_arb.sv | 120 ++++++++++++
 tb/tb_vram_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arb.sv
// VRAM arbiter: video generator has absolute priority; blitter and copper share the remaining slots.
// Define VRAM_ARB_ROUND_ROBIN_EN for round-robin blit/cop arbitration, otherwise blit has fixed priority.
module vram_arb #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_i,
  // video generator
  input  logic              vgen_sel_i,
  input  logic [ADDR_W-1:0] vgen_addr_i,
  output logic [15:0]       vgen_data_o,
  output logic              vgen_valid_o,
  // blitter
  input  logic              blit_req_i,
  input  logic              blit_wr_i,
  input  logic [3:0]        blit_mask_i,
  input  logic [ADDR_W-1:0] blit_addr_i,
  input  logic [15:0]       blit_data_i,
  output logic              blit_ack_o,
  output logic [15:0]       blit_data_o,
  output logic              blit_valid_o,
  // copper
  input  logic              cop_req_i,
  input  logic [ADDR_W-1:0] cop_addr_i,
  output logic              cop_ack_o,
  output logic [15:0]       cop_data_o,
  output logic              cop_valid_o,
  // VRAM
  output logic              vram_sel_o,
  output logic              vram_wr_o,
  output logic [3:0]        vram_mask_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic [15:0]       vram_data_o,
  input  logic [15:0]       vram_data_i
);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_VGEN = 2'd1;
  localparam logic [1:0] TAG_BLIT = 2'd2;
  localparam logic [1:0] TAG_COP  = 2'd3;

  logic        grant_blit;
  logic        grant_cop;
  logic [1:0]  tag_d;
  logic [1:0]  tag_q;
  logic [15:0] vgen_hold_q;
  logic [15:0] blit_hold_q;
  logic [15:0] cop_hold_q;

`ifdef VRAM_ARB_ROUND_ROBIN_EN
  // 1 = copper was served last, so blit wins the next contested slot
  logic rr_last_q;
`endif

  // Grant selection for the slots video leaves free; no grants while in reset
  always_comb begin
    grant_blit = 1'b0;
    grant_cop  = 1'b0;
    if (!vgen_sel_i && !reset_i) begin
`ifdef VRAM_ARB_ROUND_ROBIN_EN
      if (blit_req_i && (!cop_req_i || rr_last_q)) grant_blit = 1'b1;
      else if (cop_req_i)                          grant_cop  = 1'b1;
`else
      if (blit_req_i)     grant_blit = 1'b1;
      else if (cop_req_i) grant_cop  = 1'b1;
`endif
    end
  end

  // VRAM command and read-return tag for this cycle
  always_comb begin
    vram_sel_o  = vgen_sel_i | grant_blit | grant_cop;
    vram_wr_o   = grant_blit & blit_wr_i;
    vram_mask_o = vram_wr_o ? blit_mask_i : 4'b0000;
    vram_data_o = blit_data_i;
    vram_addr_o = blit_addr_i;
    if (vgen_sel_i)     vram_addr_o = vgen_addr_i;
    else if (grant_cop) vram_addr_o = cop_addr_i;
    tag_d = TAG_NONE;
    if (vgen_sel_i)                    tag_d = TAG_VGEN;
    else if (grant_blit && !blit_wr_i) tag_d = TAG_BLIT;
    else if (grant_cop)                tag_d = TAG_COP;
  end

  assign blit_ack_o = grant_blit;
  assign cop_ack_o  = grant_cop;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      tag_q       <= TAG_NONE;
      vgen_hold_q <= 16'h0000;
      blit_hold_q <= 16'h0000;
      cop_hold_q  <= 16'h0000;
    end else begin
      tag_q <= tag_d;
      if (tag_q == TAG_VGEN) vgen_hold_q <= vram_data_i;
      if (tag_q == TAG_BLIT) blit_hold_q <= vram_data_i;
      if (tag_q == TAG_COP)  cop_hold_q  <= vram_data_i;
    end
  end

`ifdef VRAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i)         rr_last_q <= 1'b1;
    else if (grant_blit) rr_last_q <= 1'b0;
    else if (grant_cop)  rr_last_q <= 1'b1;
  end
`endif

  // Returned data is visible in the valid cycle, then held until the owner's next valid
  always_comb begin
    vgen_valid_o = (tag_q == TAG_VGEN);
    blit_valid_o = (tag_q == TAG_BLIT);
    cop_valid_o  = (tag_q == TAG_COP);
    vgen_data_o  = vgen_valid_o ? vram_data_i : vgen_hold_q;
    blit_data_o  = blit_valid_o ? vram_data_i : blit_hold_q;
    cop_data_o   = cop_valid_o  ? vram_data_i : cop_hold_q;
  end

endmodule

// File: tb/tb_vram_arb.sv
// Self-checking bench for vram_arb: directed scenarios plus randomized traffic against a reference model.
module tb_vram_arb;

  localparam int unsigned ADDR_W = 16;
  localparam int NONE = 0;
  localparam int VGEN = 1;
  localparam int BLIT = 2;
  localparam int COP  = 3;

  logic              clk;
  logic              rst;
  logic              vgen_sel;
  logic [ADDR_W-1:0] vgen_addr;
  logic [15:0]       vgen_data;
  logic              vgen_valid;
  logic              blit_req;
  logic              blit_wr;
  logic [3:0]        blit_mask;
  logic [ADDR_W-1:0] blit_addr;
  logic [15:0]       blit_wdata;
  logic              blit_ack;
  logic [15:0]       blit_rdata;
  logic              blit_valid;
  logic              cop_req;
  logic [ADDR_W-1:0] cop_addr;
  logic              cop_ack;
  logic [15:0]       cop_data;
  logic              cop_valid;
  logic              vram_sel;
  logic              vram_wr;
  logic [3:0]        vram_mask;
  logic [ADDR_W-1:0] vram_addr;
  logic [15:0]       vram_wdata;
  logic [15:0]       vram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          m_tag;
  int          m_last;
  logic [15:0] m_hold [4];
  int          cur_own;
  bit          cur_rd;

  vram_arb #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_i(rst),
    .vgen_sel_i(vgen_sel), .vgen_addr_i(vgen_addr), .vgen_data_o(vgen_data), .vgen_valid_o(vgen_valid),
    .blit_req_i(blit_req), .blit_wr_i(blit_wr), .blit_mask_i(blit_mask), .blit_addr_i(blit_addr),
    .blit_data_i(blit_wdata), .blit_ack_o(blit_ack), .blit_data_o(blit_rdata), .blit_valid_o(blit_valid),
    .cop_req_i(cop_req), .cop_addr_i(cop_addr), .cop_ack_o(cop_ack), .cop_data_o(cop_data),
    .cop_valid_o(cop_valid),
    .vram_sel_o(vram_sel), .vram_wr_o(vram_wr), .vram_mask_o(vram_mask), .vram_addr_o(vram_addr),
    .vram_data_o(vram_wdata), .vram_data_i(vram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tag  = NONE;
    m_last = COP;
    for (int i = 0; i < 4; i++) m_hold[i] = 16'h0000;
  endtask

  // Predict who owns VRAM this cycle and check every output; called at posedge+1
  task automatic check_cycle();
    int          own;
    logic [15:0] exp_addr;
    bit          is_wr;
    #2;
    if (vgen_sel)                own = VGEN;
    else if (rst)                own = NONE;
    else if (blit_req && cop_req) begin
`ifdef VRAM_ARB_ROUND_ROBIN_EN
      own = (m_last == COP) ? BLIT : COP;
`else
      own = BLIT;
`endif
    end
    else if (blit_req)           own = BLIT;
    else if (cop_req)            own = COP;
    else                         own = NONE;
    is_wr   = (own == BLIT) && blit_wr;
    cur_own = own;
    cur_rd  = (own != NONE) && !is_wr;
    exp_addr = (own == VGEN) ? vgen_addr : (own == COP) ? cop_addr : blit_addr;
    chk("vram_sel", 32'(vram_sel), 32'(own != NONE));
    if (own != NONE) chk("vram_addr", 32'(vram_addr), 32'(exp_addr));
    chk("vram_wr", 32'(vram_wr), 32'(is_wr));
    chk("vram_mask", 32'(vram_mask), is_wr ? 32'(blit_mask) : 32'd0);
    chk("vram_data", 32'(vram_wdata), 32'(blit_wdata));
    chk("blit_ack", 32'(blit_ack), 32'(own == BLIT));
    chk("cop_ack", 32'(cop_ack), 32'(own == COP));
    chk("vgen_valid", 32'(vgen_valid), 32'(m_tag == VGEN));
    chk("blit_valid", 32'(blit_valid), 32'(m_tag == BLIT));
    chk("cop_valid", 32'(cop_valid), 32'(m_tag == COP));
    chk("vgen_data", 32'(vgen_data), 32'((m_tag == VGEN) ? vram_rdata : m_hold[VGEN]));
    chk("blit_data", 32'(blit_rdata), 32'((m_tag == BLIT) ? vram_rdata : m_hold[BLIT]));
    chk("cop_data", 32'(cop_data), 32'((m_tag == COP) ? vram_rdata : m_hold[COP]));
  endtask

  // Clock edge: returned data lands with the owner, new read gets tagged, last-served updates
  task automatic advance();
    @(posedge clk);
    if (m_tag != NONE) m_hold[m_tag] = vram_rdata;
    m_tag = cur_rd ? cur_own : NONE;
    if (cur_own == BLIT || cur_own == COP) m_last = cur_own;
    #1;
  endtask

  task automatic idle_inputs();
    vgen_sel = 1'b0; vgen_addr = '0;
    blit_req = 1'b0; blit_wr = 1'b0; blit_mask = 4'h0; blit_addr = '0; blit_wdata = 16'h0;
    cop_req = 1'b0; cop_addr = '0;
    vram_rdata = 16'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit b_pend;
    bit c_pend;
    rst = 1'b1;
    model_reset();
    idle_inputs();
    #1;
    // acks stay low and everything is cleared while reset is held
    blit_req = 1'b1; cop_req = 1'b1;
    check_cycle();
    chk("rst_blit_ack", 32'(blit_ack), 32'd0);
    chk("rst_cop_ack", 32'(cop_ack), 32'd0);
    advance();
    rst = 1'b0;
    idle_inputs();

    // blit blocked by video for 3 cycles, acked on the first free slot
    vgen_sel = 1'b1; vgen_addr = 16'h4000;
    blit_req = 1'b1; blit_addr = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      check_cycle();
      chk("vgen_block_ack", 32'(blit_ack), 32'd0);
      advance();
      vgen_addr = vgen_addr + 16'h1;
    end
    vgen_sel = 1'b0;
    check_cycle();
    chk("blit_after_vgen", 32'(blit_ack), 32'd1);
    advance();
    blit_req = 1'b0;

    // blit read 0x0010 returns 0xBEEF one cycle after its ack
    blit_req = 1'b1; blit_addr = 16'h0010;
    check_cycle();
    chk("blit_rd_ack", 32'(blit_ack), 32'd1);
    advance();
    blit_req = 1'b0; vram_rdata = 16'hBEEF;
    check_cycle();
    chk("blit_rd_valid", 32'(blit_valid), 32'd1);
    chk("blit_rd_data", 32'(blit_rdata), 32'hBEEF);
    chk("blit_rd_cop_valid", 32'(cop_valid), 32'd0);
    advance();
    vram_rdata = 16'h0;
    check_cycle();
    chk("blit_rd_hold", 32'(blit_rdata), 32'hBEEF);
    advance();

    // blit write: mask and data reach VRAM, no valid follows
    blit_req = 1'b1; blit_wr = 1'b1; blit_addr = 16'h0020; blit_mask = 4'b0101; blit_wdata = 16'hA5A5;
    check_cycle();
    chk("wr_vram_wr", 32'(vram_wr), 32'd1);
    chk("wr_vram_mask", 32'(vram_mask), 32'h5);
    chk("wr_vram_data", 32'(vram_wdata), 32'hA5A5);
    advance();
    blit_req = 1'b0; blit_wr = 1'b0;
    check_cycle();
    chk("wr_no_valid", 32'(blit_valid), 32'd0);
    advance();

    // continuous contention after reset
    do_reset();
    blit_req = 1'b1; cop_req = 1'b1; blit_addr = 16'h0100; cop_addr = 16'h0200;
    for (int i = 0; i < 6; i++) begin
      check_cycle();
`ifdef VRAM_ARB_ROUND_ROBIN_EN
      chk("contend_blit_ack", 32'(blit_ack), 32'(i % 2 == 0));
      chk("contend_cop_ack", 32'(cop_ack), 32'(i % 2 == 1));
`else
      chk("contend_blit_ack", 32'(blit_ack), 32'd1);
      chk("contend_cop_ack", 32'(cop_ack), 32'd0);
`endif
      advance();
    end
    idle_inputs();
    check_cycle();
    advance();

    // reset pulse with a copper read in flight kills its valid
    do_reset();
    cop_req = 1'b1; cop_addr = 16'h0300;
    check_cycle();
    chk("cop_rd_ack", 32'(cop_ack), 32'd1);
    advance();
    cop_req = 1'b0; vram_rdata = 16'h1357;
    rst = 1'b1;
    model_reset();
    #1;
    rst = 1'b0;
    blit_req = 1'b1; cop_req = 1'b1;
    check_cycle();
    chk("rst_kill_cop_valid", 32'(cop_valid), 32'd0);
    chk("rst_first_blit", 32'(blit_ack), 32'd1);
    advance();
    check_cycle();
    chk("rst_kill_cop_valid2", 32'(cop_valid), 32'd0);
    advance();
    idle_inputs();
    check_cycle();
    advance();

    // randomized traffic: requesters hold until ack, occasionally cancel
    b_pend = 1'b0;
    c_pend = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      vgen_sel   = ($urandom_range(0, 2) == 0);
      vgen_addr  = ADDR_W'($urandom);
      vram_rdata = 16'($urandom);
      if (!b_pend) begin
        if ($urandom_range(0, 1) == 1) begin
          b_pend = 1'b1;
          blit_req = 1'b1; blit_wr = 1'($urandom); blit_mask = 4'($urandom);
          blit_addr = ADDR_W'($urandom); blit_wdata = 16'($urandom);
        end else begin
          blit_req = 1'b0;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        b_pend = 1'b0;
        blit_req = 1'b0;
      end
      if (!c_pend) begin
        c_pend = ($urandom_range(0, 1) == 1);
        cop_req = c_pend;
        if (c_pend) cop_addr = ADDR_W'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        c_pend = 1'b0;
        cop_req = 1'b0;
      end
      check_cycle();
      advance();
      if (cur_own == BLIT) begin b_pend = 1'b0; blit_req = 1'b0; end
      if (cur_own == COP)  begin c_pend = 1'b0; cop_req = 1'b0; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
